// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request, output FIFO.
// A redirect flushes the FIFO and marks any in-flight fetch stale.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode
);

    localparam logic [XLEN-1:0] NOP = XLEN'(32'h13);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] tgt;

    logic [XLEN-1:0] fifo_d [DEPTH];
    logic [XLEN-1:0] fifo_p [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic fire;
    logic flush;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign tgt   = {redirect_pc[XLEN-1:2], 2'b00};
    assign flush = redirect && (state != IDLE);

    assign imem_req  = (state == REQ) && (count < CW'(DEPTH));
    assign imem_addr = pc;
    assign fire      = imem_req && imem_gnt;

    assign instr_valid = (count != '0);
    assign push = (state == WAIT) && imem_rvalid && !flush;
    assign pop  = instr_valid && instr_ready && !flush;

    assign instr    = instr_valid ? fifo_d[rd_ptr] : NOP;
    assign instr_pc = instr_valid ? fifo_p[rd_ptr] : '0;
    assign opcode   = instr[6:0];

    // Fetch FSM: PC advance, request tracking, stale-response dropping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            unique case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (redirect) begin
                        pc <= tgt;
                        if (fire)
                            state <= DROP;
                    end else if (fire) begin
                        pc     <= pc + XLEN'(4);
                        req_pc <= pc;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        pc    <= tgt;
                        state <= imem_rvalid ? REQ : DROP;
                    end else if (imem_rvalid) begin
                        state <= REQ;
                    end
                end
                DROP: begin
                    if (redirect)
                        pc <= tgt;
                    if (imem_rvalid)
                        state <= REQ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO occupancy and pointers; redirect empties it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= nxt(wr_ptr);
            if (pop)
                rd_ptr <= nxt(rd_ptr);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // FIFO storage; contents are only meaningful under count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_d[wr_ptr] <= imem_rdata;
            fifo_p[wr_ptr] <= req_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed vector table, hand sequences,
// and randomized traffic against an instruction-stream reference model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h13;
    localparam logic [31:0] ADD = 32'h33;
    localparam logic [31:0] BAD = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;

    logic        reset2 = 1'b1;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_gnt2 = 1'b1;
    logic        imem_rvalid2 = 1'b0;
    logic [31:0] imem_rdata2 = 32'h33;
    logic        redirect2 = 1'b0;
    logic [31:0] redirect_pc2 = '0;
    logic        instr_valid2;
    logic        instr_ready2 = 1'b1;
    logic [31:0] instr2;
    logic [31:0] instr_pc2;
    logic [6:0]  opcode2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .opcode(opcode)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFFFFFC), .DEPTH(2)) dut2 (
        .clk(clk), .reset(reset2),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_gnt(imem_gnt2), .imem_rvalid(imem_rvalid2),
        .imem_rdata(imem_rdata2),
        .redirect(redirect2), .redirect_pc(redirect_pc2),
        .instr_valid(instr_valid2), .instr_ready(instr_ready2),
        .instr(instr2), .instr_pc(instr_pc2), .opcode(opcode2)
    );

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;

    vec_t vt[18];
    ent_t mq[$];

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endfunction

    function automatic vec_t mk(logic g, logic rv, logic [31:0] rd,
                                logic rdy, logic rr, logic [31:0] rp,
                                logic er, logic [31:0] ea, logic ev,
                                logic [31:0] ep);
        vec_t v;
        v.gnt = g; v.rv = rv; v.rd = rd; v.rdy = rdy;
        v.redir = rr; v.rpc = rp;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev;
        v.e_instr = ev ? ADD : NOP;
        v.e_pc = ep;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_dut;
        reset = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        redirect = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    initial begin
        bit          fp;
        bit          f;
        bit          idle;
        bit          outst;
        bit          stale;
        bit          ereq;
        bit          fire;
        bit          popd;
        logic [31:0] epc;
        logic [31:0] mpc;
        logic [31:0] got[2];
        int          n;

        vt[0]  = mk(1, 0, 0,   1, 0, 0,     0, 32'h000, 0, 0);
        vt[1]  = mk(1, 0, 0,   1, 0, 0,     1, 32'h000, 0, 0);
        vt[2]  = mk(0, 1, ADD, 1, 0, 0,     0, 32'h004, 0, 0);
        vt[3]  = mk(1, 0, 0,   1, 0, 0,     1, 32'h004, 1, 32'h000);
        vt[4]  = mk(0, 1, ADD, 1, 0, 0,     0, 32'h008, 0, 0);
        vt[5]  = mk(1, 0, 0,   1, 0, 0,     1, 32'h008, 1, 32'h004);
        vt[6]  = mk(0, 0, 0,   1, 1, 32'h100, 0, 32'h00C, 0, 0);
        vt[7]  = mk(0, 0, 0,   1, 0, 0,     0, 32'h100, 0, 0);
        vt[8]  = mk(0, 1, BAD, 1, 0, 0,     0, 32'h100, 0, 0);
        vt[9]  = mk(1, 0, 0,   1, 0, 0,     1, 32'h100, 0, 0);
        vt[10] = mk(0, 1, ADD, 1, 0, 0,     0, 32'h104, 0, 0);
        vt[11] = mk(1, 0, 0,   1, 0, 0,     1, 32'h104, 1, 32'h100);
        vt[12] = mk(0, 1, BAD, 1, 1, 32'h203, 0, 32'h108, 0, 0);
        vt[13] = mk(1, 0, 0,   1, 1, 32'h203, 1, 32'h200, 0, 0);
        vt[14] = mk(0, 1, BAD, 1, 0, 0,     0, 32'h200, 0, 0);
        vt[15] = mk(1, 0, 0,   1, 0, 0,     1, 32'h200, 0, 0);
        vt[16] = mk(0, 1, ADD, 1, 0, 0,     0, 32'h204, 0, 0);
        vt[17] = mk(0, 0, 0,   1, 0, 0,     1, 32'h204, 1, 32'h200);

        #1;
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", instr_pc, 32'h0);

        // Directed table: stream, redirect in WAIT, redirect with rvalid/gnt.
        rst_dut();
        for (int i = 0; i < 18; i++) begin
            chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vt[i].e_req));
            chk($sformatf("v%0d_addr", i), imem_addr, vt[i].e_addr);
            chk($sformatf("v%0d_valid", i), 32'(instr_valid),
                32'(vt[i].e_valid));
            chk($sformatf("v%0d_instr", i), instr, vt[i].e_instr);
            chk($sformatf("v%0d_ipc", i), instr_pc, vt[i].e_pc);
            chk($sformatf("v%0d_opc", i), 32'(opcode),
                32'(vt[i].e_instr[6:0]));
            imem_gnt = vt[i].gnt;
            imem_rvalid = vt[i].rv;
            imem_rdata = vt[i].rd;
            instr_ready = vt[i].rdy;
            redirect = vt[i].redir;
            redirect_pc = vt[i].rpc;
            tick;
        end

        // Backpressure: FIFO fills, request gated, head held, then drains.
        rst_dut();
        instr_ready = 1'b0;
        imem_gnt = 1'b1;
        imem_rdata = ADD;
        fp = 0;
        for (int i = 0; i < 12; i++) begin
            if (i >= 4)
                chk("bp_hold_pc", instr_pc, 32'h0);
            imem_rvalid = fp;
            f = imem_req && imem_gnt;
            tick;
            fp = f;
        end
        chk("bp_req", 32'(imem_req), 32'h0);
        chk("bp_valid", 32'(instr_valid), 32'h1);
        chk("bp_addr", imem_addr, 32'h8);
        imem_rvalid = 1'b0;
        instr_ready = 1'b1;
        chk("bp_d0", instr_pc, 32'h0);
        tick;
        chk("bp_d1", instr_pc, 32'h4);
        chk("bp_req2", 32'(imem_req), 32'h1);
        chk("bp_addr2", imem_addr, 32'h8);
        tick;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        tick;
        imem_rvalid = 1'b0;
        chk("bp_d2", instr_pc, 32'h8);

        // Reset asserted mid-WAIT with a response arriving during reset.
        rst_dut();
        instr_ready = 1'b0;
        imem_gnt = 1'b1;
        tick;
        tick;
        imem_rvalid = 1'b1;
        imem_rdata = ADD;
        tick;
        imem_rvalid = 1'b0;
        tick;
        chk("mr_pre_valid", 32'(instr_valid), 32'h1);
        chk("mr_pre_addr", imem_addr, 32'h8);
        reset = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = BAD;
        #1;
        chk("mr_req", 32'(imem_req), 32'h0);
        chk("mr_addr", imem_addr, 32'h0);
        chk("mr_valid", 32'(instr_valid), 32'h0);
        chk("mr_instr", instr, NOP);
        chk("mr_ipc", instr_pc, 32'h0);
        tick;
        tick;
        imem_rvalid = 1'b0;
        reset = 1'b0;
        chk("mr_idle_valid", 32'(instr_valid), 32'h0);
        imem_gnt = 1'b1;
        tick;
        chk("mr_restart_req", 32'(imem_req), 32'h1);
        chk("mr_restart_addr", imem_addr, 32'h0);
        tick;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = ADD;
        tick;
        imem_rvalid = 1'b0;
        chk("mr_first_valid", 32'(instr_valid), 32'h1);
        chk("mr_first_pc", instr_pc, 32'h0);
        chk("mr_first_instr", instr, ADD);

        // Randomized traffic vs. expected instruction-stream model.
        rst_dut();
        mq.delete();
        idle = 1; outst = 0; stale = 0; epc = 0; mpc = 0;
        for (int c = 0; c < 2000; c++) begin
            chk("rnd_valid", 32'(instr_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("rnd_instr", instr, mq[0].d);
                chk("rnd_ipc", instr_pc, mq[0].p);
                chk("rnd_opc", 32'(opcode), 32'(mq[0].d[6:0]));
            end else begin
                chk("rnd_nop", instr, NOP);
                chk("rnd_zpc", instr_pc, 32'h0);
            end
            ereq = !idle && !outst && (mq.size() < 2);
            chk("rnd_req", 32'(imem_req), 32'(ereq));
            if (ereq)
                chk("rnd_addr", imem_addr, epc);
            imem_gnt = ($urandom % 2) == 0;
            instr_ready = ($urandom % 4) != 0;
            redirect = ($urandom % 12) == 0;
            redirect_pc = $urandom;
            imem_rvalid = outst && (($urandom % 3) == 0);
            imem_rdata = $urandom;
            fire = ereq && imem_gnt;
            popd = (mq.size() != 0) && instr_ready;
            if (idle) begin
                idle = 0;
            end else if (redirect) begin
                mq.delete();
                epc = {redirect_pc[31:2], 2'b00};
                if (fire) begin
                    outst = 1; stale = 1;
                end else if (outst && imem_rvalid) begin
                    outst = 0; stale = 0;
                end else if (outst) begin
                    stale = 1;
                end
            end else begin
                if (popd)
                    void'(mq.pop_front());
                if (outst && imem_rvalid) begin
                    if (!stale)
                        mq.push_back('{imem_rdata, mpc});
                    outst = 0; stale = 0;
                end
                if (fire) begin
                    outst = 1; stale = 0;
                    mpc = epc;
                    epc = epc + 32'd4;
                end
            end
            tick;
        end
        redirect = 1'b0;
        imem_rvalid = 1'b0;

        // PC wrap from RESET_PC = 0xFFFFFFFC.
        got[0] = 32'h1;
        got[1] = 32'h1;
        n = 0;
        fp = 0;
        reset2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid2 && n < 2) begin
                got[n] = instr_pc2;
                n++;
            end
            imem_rvalid2 = fp;
            f = imem_req2 && imem_gnt2;
            tick;
            fp = f;
        end
        chk("wrap_pc0", got[0], 32'hFFFFFFFC);
        chk("wrap_pc1", got[1], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
